// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: main/side/walk sequencing controller with programmable intervals.
// Optional macro WALK_COUNTDOWN_EN adds the registered Walk_Remain output.
module traffic_light_fsm #(
    parameter int T_BASE = 6,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Tick_1Hz,
    input  logic             Reset_Sync,
    input  logic             Sensor_Sync,
    input  logic             WR_Sync,
    input  logic             Prog_Sync,
    input  logic [1:0]       Time_Param_Sel,
    input  logic [CNT_W-1:0] Time_Value,
    output logic [2:0]       Main_Lights,
    output logic [2:0]       Side_Lights,
    output logic             Walk_Lamp,
`ifdef WALK_COUNTDOWN_EN
    output logic [CNT_W-1:0] Walk_Remain,
`endif
    output logic [2:0]       State
);

    typedef enum logic [2:0] {
        MAIN_GRN  = 3'd0,
        MAIN_GRN2 = 3'd1,
        MAIN_YEL  = 3'd2,
        WALK      = 3'd3,
        SIDE_GRN  = 3'd4,
        SIDE_EXT  = 3'd5,
        SIDE_YEL  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] BASE_RST = CNT_W'(T_BASE);
    localparam logic [CNT_W-1:0] EXT_RST  = CNT_W'(T_EXT);
    localparam logic [CNT_W-1:0] YEL_RST  = CNT_W'(T_YEL);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] base_q, base_d;
    logic [CNT_W-1:0] ext_q, ext_d;
    logic [CNT_W-1:0] yel_q, yel_d;
    logic             pend_q, pend_d;
    logic             prog_prev_q;
    logic [2:0]       main_q, main_d;
    logic [2:0]       side_q, side_d;
    logic             lamp_q, lamp_d;
    logic             prog_ev;
    logic [CNT_W-1:0] prog_val;
`ifdef WALK_COUNTDOWN_EN
    logic [CNT_W-1:0] remain_q, remain_d;
`endif

    // Interval each state times out after.
    function automatic logic [CNT_W-1:0] interval_of(
        input state_t           s,
        input logic [CNT_W-1:0] b,
        input logic [CNT_W-1:0] e,
        input logic [CNT_W-1:0] y
    );
        unique case (s)
            WALK, SIDE_EXT:     interval_of = e;
            MAIN_YEL, SIDE_YEL: interval_of = y;
            default:            interval_of = b;
        endcase
    endfunction

    assign prog_ev  = Prog_Sync & ~prog_prev_q;
    assign prog_val = (Time_Value == '0) ? ONE : Time_Value;

    // Next state, timer, interval bank, walk latch and registered light values.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        base_d  = base_q;
        ext_d   = ext_q;
        yel_d   = yel_q;
        pend_d  = pend_q | WR_Sync;
        if (Reset_Sync) begin
            state_d = MAIN_GRN;
            timer_d = base_q;
            pend_d  = 1'b0;
        end else if (prog_ev) begin
            unique case (Time_Param_Sel)
                2'b00:   base_d = prog_val;
                2'b01:   ext_d  = prog_val;
                2'b10:   yel_d  = prog_val;
                default: ;
            endcase
            state_d = MAIN_GRN;
            timer_d = base_d;
        end else if (Tick_1Hz) begin
            if (timer_q == ONE) begin
                unique case (state_q)
                    MAIN_GRN:  state_d = Sensor_Sync ? MAIN_YEL : MAIN_GRN2;
                    MAIN_GRN2: state_d = MAIN_YEL;
                    MAIN_YEL:  state_d = pend_q ? WALK : SIDE_GRN;
                    WALK:      state_d = SIDE_GRN;
                    SIDE_GRN:  state_d = Sensor_Sync ? SIDE_EXT : SIDE_YEL;
                    SIDE_EXT:  state_d = SIDE_YEL;
                    default:   state_d = MAIN_GRN;
                endcase
                timer_d = interval_of(state_d, base_q, ext_q, yel_q);
                if (state_d == WALK) pend_d = 1'b0;
            end else begin
                timer_d = timer_q - ONE;
            end
        end

        main_d = 3'b100;
        side_d = 3'b100;
        lamp_d = 1'b0;
        unique case (state_d)
            MAIN_GRN, MAIN_GRN2: main_d = 3'b001;
            MAIN_YEL:            main_d = 3'b010;
            WALK:                lamp_d = 1'b1;
            SIDE_GRN, SIDE_EXT:  side_d = 3'b001;
            SIDE_YEL:            side_d = 3'b010;
            default: begin
                main_d = 3'b001;
                side_d = 3'b100;
            end
        endcase
`ifdef WALK_COUNTDOWN_EN
        remain_d = (state_d == WALK) ? timer_d : '0;
`endif
    end

    // State, timer, intervals, walk latch and all outputs update together.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= MAIN_GRN;
            timer_q     <= BASE_RST;
            base_q      <= BASE_RST;
            ext_q       <= EXT_RST;
            yel_q       <= YEL_RST;
            pend_q      <= 1'b0;
            prog_prev_q <= 1'b0;
            main_q      <= 3'b001;
            side_q      <= 3'b100;
            lamp_q      <= 1'b0;
`ifdef WALK_COUNTDOWN_EN
            remain_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            base_q      <= base_d;
            ext_q       <= ext_d;
            yel_q       <= yel_d;
            pend_q      <= pend_d;
            prog_prev_q <= Prog_Sync;
            main_q      <= main_d;
            side_q      <= side_d;
            lamp_q      <= lamp_d;
`ifdef WALK_COUNTDOWN_EN
            remain_q    <= remain_d;
`endif
        end
    end

    assign Main_Lights = main_q;
    assign Side_Lights = side_q;
    assign Walk_Lamp   = lamp_q;
    assign State       = state_q;
`ifdef WALK_COUNTDOWN_EN
    assign Walk_Remain = remain_q;
`endif

endmodule
